// File: rtl/gpio_host_port_if.sv
// rtl/gpio_host_port_if.sv - gpio_out event stream between the host port and its consumer
interface gpio_host_port_if;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_ready;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/gpio_host_port.sv
// rtl/gpio_host_port.sv - board-side GPIO port: synchronised inputs, gpio_out change FIFO
// Optional input debounce FSM is built when GPIO_DEBOUNCE_EN is defined.
module gpio_host_port #(
  parameter int IN_W       = 18,
  parameter int DEB_CYCLES = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    sw_in,
  input  logic               key_n,
  output logic [31:0]        gpio_in,
  input  logic [31:0]        gpio_out,
  gpio_host_port_if.master   evt,
  output logic               evt_overflow,
  input  logic               clr_overflow
);
  localparam int VW = IN_W + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  if (IN_W < 1 || IN_W > 31) begin : g_bad_in_w
    $error("IN_W must be 1..31");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [VW-1:0] sync1, s, acc;
  logic [31:0]   acc_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= {~key_n, sw_in};
      s     <= sync1;
    end
  end

  // Key lands in bit 31, switches in the low bits, everything between reads zero
  always_comb begin
    acc_word           = '0;
    acc_word[IN_W-1:0] = acc[IN_W-1:0];
    acc_word[31]       = acc[IN_W];
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  typedef enum logic {STABLE, SETTLING} deb_state_t;

  deb_state_t    state, state_nx;
  logic [VW-1:0] cand, cand_nx, acc_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= STABLE;
      cand    <= '0;
      cnt     <= '0;
      acc     <= '0;
      gpio_in <= '0;
    end else begin
      state   <= state_nx;
      cand    <= cand_nx;
      cnt     <= cnt_nx;
      acc     <= acc_nx;
      gpio_in <= acc_word;
    end
  end

  // A return to the accepted value is a rejected glitch, checked before a restart
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    acc_nx   = acc;
    case (state)
      STABLE: begin
        if (s != acc) begin
          state_nx = SETTLING;
          cand_nx  = s;
          cnt_nx   = CW'(1);
        end
      end
      SETTLING: begin
        if (s == acc) begin
          state_nx = STABLE;
        end else if (s != cand) begin
          cand_nx = s;
          cnt_nx  = CW'(1);
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
          acc_nx   = cand;
          state_nx = STABLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = STABLE;
    endcase
  end
`else
  // Without debounce, acc itself is the gpio_in register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= s;
  end

  assign gpio_in = acc_word;
`endif

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] prev_out;
  logic        empty, full, change, pop, wr_en, drop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign change = (gpio_out != prev_out);
  assign pop    = ~empty & evt.evt_ready;
  assign wr_en  = change & (~full | pop);
  assign drop   = change & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      prev_out     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (change) prev_out <= gpio_out;
      if (wr_en)  wr_ptr   <= wr_ptr + 1'b1;
      if (pop)    rd_ptr   <= rd_ptr + 1'b1;
      if (drop)              evt_overflow <= 1'b1;
      else if (clr_overflow) evt_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= gpio_out;
  end

  assign evt.evt_valid = ~empty;
  assign evt.evt_data  = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_gpio_host_port.sv
// tb/tb_gpio_host_port.sv - directed table-driven bench for gpio_host_port
module tb_gpio_host_port;
  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sw_in;
  logic        key_n;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        evt_overflow;
  logic        clr_overflow;
  int          checks = 0;
  int          errors = 0;

  gpio_host_port_if evt_if ();

  gpio_host_port #(.IN_W(18), .DEB_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_in        (sw_in),
    .key_n        (key_n),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .evt          (evt_if.master),
    .evt_overflow (evt_overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic        rdy;
    logic        clr;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    // out, rdy, clr, exp_valid, exp_data, exp_overflow (values after the edge)
    tbl.push_back('{32'hA5, 1'b0, 1'b0, 1'b1, 32'hA5, 1'b0});
    tbl.push_back('{32'hA5, 1'b0, 1'b0, 1'b1, 32'hA5, 1'b0});
    tbl.push_back('{32'hA5, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0});
    tbl.push_back('{32'h1,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0});
    tbl.push_back('{32'h2,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0});
    tbl.push_back('{32'h3,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0});
    tbl.push_back('{32'h4,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0});
    tbl.push_back('{32'h5,  1'b0, 1'b0, 1'b1, 32'h1,  1'b1});
    tbl.push_back('{32'h5,  1'b1, 1'b0, 1'b1, 32'h2,  1'b1});
    tbl.push_back('{32'h5,  1'b1, 1'b0, 1'b1, 32'h3,  1'b1});
    tbl.push_back('{32'h5,  1'b1, 1'b0, 1'b1, 32'h4,  1'b1});
    tbl.push_back('{32'h5,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1});
    tbl.push_back('{32'h5,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0});
    tbl.push_back('{32'h6,  1'b0, 1'b0, 1'b1, 32'h6,  1'b0});
    tbl.push_back('{32'h7,  1'b0, 1'b0, 1'b1, 32'h6,  1'b0});
    tbl.push_back('{32'h8,  1'b0, 1'b0, 1'b1, 32'h6,  1'b0});
    tbl.push_back('{32'h10, 1'b0, 1'b0, 1'b1, 32'h6,  1'b0});
    tbl.push_back('{32'h9,  1'b1, 1'b0, 1'b1, 32'h7,  1'b0});
    tbl.push_back('{32'h9,  1'b1, 1'b0, 1'b1, 32'h8,  1'b0});
    tbl.push_back('{32'h9,  1'b1, 1'b0, 1'b1, 32'h10, 1'b0});
    tbl.push_back('{32'h9,  1'b1, 1'b0, 1'b1, 32'h9,  1'b0});
    tbl.push_back('{32'h9,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0});
    tbl.push_back('{32'h1,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0});
    tbl.push_back('{32'h2,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0});
    tbl.push_back('{32'h3,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0});
    tbl.push_back('{32'h4,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0});
    tbl.push_back('{32'h5,  1'b0, 1'b1, 1'b1, 32'h1,  1'b1});
    tbl.push_back('{32'h5,  1'b0, 1'b0, 1'b1, 32'h1,  1'b1});
    tbl.push_back('{32'h5,  1'b1, 1'b0, 1'b1, 32'h2,  1'b1});

    rst              = 1'b1;
    sw_in            = '0;
    key_n            = 1'b1;
    gpio_out         = '0;
    clr_overflow     = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    check("reset gpio_in", gpio_in, 32'h0);
    check("reset evt_valid", {31'd0, evt_if.evt_valid}, 32'h0);
    check("reset evt_data", evt_if.evt_data, 32'h0);
    check("reset evt_overflow", {31'd0, evt_overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

`ifndef GPIO_DEBOUNCE_EN
    sw_in = 18'h15A5A;
    tick(); tick(); tick();
    check("sw to gpio_in", gpio_in, 32'h0001_5A5A);
    key_n = 1'b0;
    tick(); tick();
    check("key after 2 cycles", {31'd0, gpio_in[31]}, 32'h0);
    tick();
    check("key after 3 cycles", gpio_in, 32'h8001_5A5A);
    key_n = 1'b1;
    tick(); tick(); tick();
    check("key release", gpio_in, 32'h0001_5A5A);
`else
    begin
      bit seen = 1'b0;
      sw_in = 18'h3;
      tick(); tick();
      sw_in = 18'h1;
      tick(); tick(); tick();
      sw_in = 18'h3;
      for (int i = 0; i < 8; i++) begin
        tick();
        check($sformatf("debounce settling %0d", i), gpio_in, 32'h0);
      end
      for (int i = 0; i < 10 && !seen; i++) begin
        tick();
        if (gpio_in == 32'h3) seen = 1'b1;
      end
      check("debounce accepted", {31'd0, seen}, 32'h1);
      sw_in = 18'h7;
      for (int i = 0; i < 5; i++) tick();
      sw_in = 18'h3;
      for (int i = 0; i < 20; i++) begin
        tick();
        check($sformatf("debounce pulse %0d", i), gpio_in, 32'h3);
      end
    end
`endif

    foreach (tbl[i]) begin
      gpio_out         = tbl[i].out;
      evt_if.evt_ready = tbl[i].rdy;
      clr_overflow     = tbl[i].clr;
      tick();
      check($sformatf("vec%0d evt_valid", i), {31'd0, evt_if.evt_valid}, {31'd0, tbl[i].exp_v});
      check($sformatf("vec%0d evt_data", i), evt_if.evt_data, tbl[i].exp_d);
      check($sformatf("vec%0d evt_overflow", i), {31'd0, evt_overflow}, {31'd0, tbl[i].exp_o});
    end

    // Asynchronous reset with three entries queued and overflow set
    evt_if.evt_ready = 1'b0;
    clr_overflow     = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midreset evt_valid", {31'd0, evt_if.evt_valid}, 32'h0);
    check("midreset evt_data", evt_if.evt_data, 32'h0);
    check("midreset gpio_in", gpio_in, 32'h0);
    check("midreset evt_overflow", {31'd0, evt_overflow}, 32'h0);
    gpio_out = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post reset evt_valid", {31'd0, evt_if.evt_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
